// File: rtl/pool_pkg.sv
// Shared constants, helpers and mode enum for the streaming KxK pooling stage.
// POOL_AVG_EN widens the accumulator so that average pooling can sum a full window.
package pool_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_IN_W       = 24;
    localparam int DEF_IN_H       = 24;
    localparam int DEF_POOL_K     = 2;
    localparam int DEF_NUM_CH     = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Counter width that stays legal for a range of one value.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

    localparam int OUT_W     = DEF_IN_W / DEF_POOL_K;
    localparam int OUT_H     = DEF_IN_H / DEF_POOL_K;
    localparam int BUF_DEPTH = OUT_W * DEF_NUM_CH;
`ifdef POOL_AVG_EN
    localparam int ACC_W     = DEF_DATA_WIDTH + 2 * clog2(DEF_POOL_K);
`else
    localparam int ACC_W     = DEF_DATA_WIDTH;
`endif

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

endpackage

// File: rtl/pool_partial_buf.sv
// Row of partial window results, one entry per (output column, channel).
// Combinational read, synchronous write; contents need no reset.
module pool_partial_buf
    import pool_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH,
    parameter int WIDTH = ACC_W,
    parameter int IDX_W = width_of(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/pool_kxk_stream.sv
// Streaming non-overlapping KxK pooling (signed max; average with POOL_AVG_EN)
// writing each pooled value with its feature-map RAM address.
module pool_kxk_stream
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int IN_W            = 24,
    parameter int IN_H            = 24,
    parameter int POOL_K          = 2,
    parameter int NUM_CH          = 4,
    parameter int POOL_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_start,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [POOL_ADDR_WIDTH-1:0] out_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef POOL_AVG_EN
    input  logic                       avg_mode,
`endif
    output logic                       out_last
);

    localparam int OW    = IN_W / POOL_K;
    localparam int OH    = IN_H / POOL_K;
    localparam int DEPTH = OW * NUM_CH;
`ifdef POOL_AVG_EN
    localparam int SH    = 2 * clog2(POOL_K);
    localparam int AW    = DATA_WIDTH + SH;
`else
    localparam int AW    = DATA_WIDTH;
`endif
    localparam int CW = width_of(NUM_CH);
    localparam int KW = width_of(POOL_K);
    localparam int XW = width_of(OW);
    localparam int YW = width_of(OH);
    localparam int IW = width_of(DEPTH);
    localparam int PW = POOL_ADDR_WIDTH;

    localparam logic [CW-1:0] CH_MAX = CW'(NUM_CH - 1);
    localparam logic [KW-1:0] K_MAX  = KW'(POOL_K - 1);
    localparam logic [XW-1:0] X_MAX  = XW'(OW - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(OH - 1);
    localparam logic [PW-1:0] CH_STR = PW'(OW * OH);
    localparam logic [PW-1:0] ROW_STR = PW'(OW);

    if (POOL_K < 2 || (IN_W % POOL_K) != 0 || (IN_H % POOL_K) != 0) begin : g_bad_geom
        $error("pool_kxk_stream: POOL_K must be >=2 and divide IN_W and IN_H");
    end
`ifdef POOL_AVG_EN
    if ((1 << clog2(POOL_K)) != POOL_K) begin : g_bad_k
        $error("pool_kxk_stream: average pooling needs a power-of-two POOL_K");
    end
`endif

    logic [CW-1:0] ch;
    logic [KW-1:0] kc;
    logic [KW-1:0] kr;
    logic [XW-1:0] ocol;
    logic [YW-1:0] orow;

    logic                  fire;
    logic                  first;
    logic                  closing;
    logic                  frame_end;
    logic [IW-1:0]         idx;
    logic [PW-1:0]         addr;
    logic [DATA_WIDTH-1:0] res;
    logic signed [AW-1:0]  x;
    logic signed [AW-1:0]  entry;
    logic signed [AW-1:0]  comb;

    assign in_ready  = !reset && !frame_start && (!out_valid || out_ready);
    assign fire      = in_valid && in_ready;
    assign first     = (kc == '0) && (kr == '0);
    assign closing   = (kc == K_MAX) && (kr == K_MAX);
    assign frame_end = (ch == CH_MAX) && (ocol == X_MAX) && (orow == Y_MAX);
    assign idx       = IW'(ocol) * IW'(NUM_CH) + IW'(ch);
    assign addr      = PW'(ch) * CH_STR + PW'(orow) * ROW_STR + PW'(ocol);
    assign x         = AW'($signed(in_data));

    pool_partial_buf #(
        .DEPTH (DEPTH),
        .WIDTH (AW),
        .IDX_W (IW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (fire && !closing),
        .wr_idx  (idx),
        .wr_data (comb),
        .rd_idx  (idx),
        .rd_data (entry)
    );

`ifdef POOL_AVG_EN
    pool_mode_e mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode <= POOL_MAX;
        end else if (frame_start) begin
            mode <= avg_mode ? POOL_AVG : POOL_MAX;
        end
    end
`endif

    // Ties keep the stored entry: only a strictly larger x replaces it.
    always_comb begin
        comb = x;
        if (!first) begin
            comb = (x > entry) ? x : entry;
`ifdef POOL_AVG_EN
            if (mode == POOL_AVG) comb = entry + x;
`endif
        end
    end

`ifdef POOL_AVG_EN
    assign res = (mode == POOL_AVG) ? DATA_WIDTH'(comb >>> SH) : DATA_WIDTH'(comb);
`else
    assign res = DATA_WIDTH'(comb);
`endif

    always_ff @(posedge clk) begin
        if (reset || frame_start) begin
            ch   <= '0;
            kc   <= '0;
            kr   <= '0;
            ocol <= '0;
            orow <= '0;
        end else if (fire) begin
            if (ch != CH_MAX) begin
                ch <= ch + 1'b1;
            end else begin
                ch <= '0;
                if (kc != K_MAX) begin
                    kc <= kc + 1'b1;
                end else begin
                    kc <= '0;
                    if (ocol != X_MAX) begin
                        ocol <= ocol + 1'b1;
                    end else begin
                        ocol <= '0;
                        if (kr != K_MAX) begin
                            kr <= kr + 1'b1;
                        end else begin
                            kr   <= '0;
                            orow <= (orow == Y_MAX) ? '0 : orow + 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
        end else if (fire && closing) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_addr  <= addr;
            out_last  <= frame_end;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pool_kxk_stream.sv
// Directed bench for pool_kxk_stream on a 4x4, K=2, two-channel map.
// Avg-mode window checks are built only when POOL_AVG_EN is defined.
module tb_pool_kxk_stream;

    localparam int DW   = 16;
    localparam int PAW  = 4;
    localparam int NPX  = 32;
    localparam int NOUT = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           frame_start = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [DW-1:0]  out_data;
    logic [PAW-1:0] out_addr;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic           out_last;
`ifdef POOL_AVG_EN
    logic           avg_mode = 1'b0;
`endif

    pool_kxk_stream #(
        .DATA_WIDTH      (DW),
        .IN_W            (4),
        .IN_H            (4),
        .POOL_K          (2),
        .NUM_CH          (2),
        .POOL_ADDR_WIDTH (PAW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef POOL_AVG_EN
        .avg_mode    (avg_mode),
`endif
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [DW-1:0]  frm   [NPX];
    logic [DW-1:0]  exp_d [NOUT];
    logic [DW-1:0]  got_d [$];
    logic [PAW-1:0] got_a [$];
    logic           got_l [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_a.push_back(out_addr);
            got_l.push_back(out_last);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] v);
        logic acc;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = v;
        forever begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) break;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $error("FAIL send_timeout observed=no_accept expected=accept");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_n(input int cnt);
        for (int i = 0; i < cnt; i++) send(frm[i]);
    endtask

    task automatic set_exp(input int e0, input int e1, input int e2, input int e3,
                           input int e4, input int e5, input int e6, input int e7);
        exp_d[0] = DW'(e0); exp_d[1] = DW'(e1); exp_d[2] = DW'(e2); exp_d[3] = DW'(e3);
        exp_d[4] = DW'(e4); exp_d[5] = DW'(e5); exp_d[6] = DW'(e6); exp_d[7] = DW'(e7);
    endtask

    task automatic clear_got();
        got_d.delete();
        got_a.delete();
        got_l.delete();
    endtask

    // Outputs alternate ch0/ch1 per window; ch1 lives 4 addresses higher.
    task automatic check_frame(input string tag);
        logic [PAW-1:0] ea;
        repeat (3) tick();
        chk({tag, "_count"}, got_d.size(), NOUT);
        for (int i = 0; i < NOUT && i < got_d.size(); i++) begin
            ea = PAW'((i % 2) * 4 + i / 2);
            chk($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
            chk($sformatf("%s_addr%0d", tag, i), got_a[i], ea);
            chk($sformatf("%s_last%0d", tag, i), got_l[i], (i == NOUT - 1));
        end
        clear_got();
    endtask

    task automatic load_a();
        for (int n = 0; n < 16; n++) begin
            frm[2*n]   = DW'(n);
            frm[2*n+1] = DW'(-2 * n);
        end
        set_exp(5, 0, 7, -4, 13, -16, 15, -20);
    endtask

    task automatic load_b();
        for (int n = 0; n < 16; n++) begin
            frm[2*n]   = DW'(-(n + 1));
            frm[2*n+1] = DW'(-2 * (n + 1));
        end
        set_exp(-1, -2, -3, -6, -9, -18, -11, -22);
    endtask

    task automatic load_c();
        for (int n = 0; n < 16; n++) begin
            frm[2*n]   = (n == 5) ? DW'(32767) : (n == 10) ? DW'(-32767) : DW'(-32768);
            frm[2*n+1] = DW'(100);
        end
        set_exp(32767, 100, -32768, 100, -32768, 100, -32767, 100);
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        in_valid    = 1'b1;
        in_data     = DW'(-5);
        @(negedge clk);
        chk("fs_in_ready", in_ready, 1'b0);
        tick();
        frame_start = 1'b0;
        in_valid    = 1'b0;
    endtask

    initial begin
        logic [DW-1:0]  sd;
        logic [PAW-1:0] sa;
        logic           sl;
        int c0;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_last", out_last, 1'b0);
        tick();
        reset = 1'b0;
        pulse_frame_start();

        load_a();
        c0 = cyc;
        send_n(NPX);
        chk("a_cycles", cyc - c0, NPX);
        check_frame("a");

        load_b();
        send_n(NPX);
        check_frame("b");

        load_a();
        fork
            send_n(NPX);
            begin
                for (int i = 0; i < 200; i++) begin
                    tick();
                    if (out_valid) break;
                end
                out_ready = 1'b0;
                sd = out_data;
                sa = out_addr;
                sl = out_last;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 1'b0);
                    chk("stall_valid", out_valid, 1'b1);
                    chk("stall_data", out_data, sd);
                    chk("stall_addr", out_addr, sa);
                    chk("stall_last", out_last, sl);
                end
                tick();
                out_ready = 1'b1;
            end
        join
        chk("stall_first", sd, DW'(5));
        check_frame("stall");

        load_b();
        send_n(6);
        pulse_frame_start();
        load_a();
        send_n(NPX);
        check_frame("abort");

        load_b();
        send_n(14);
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_addr", out_addr, 0);
        chk("mid_rst_last", out_last, 1'b0);
        tick();
        reset = 1'b0;
        clear_got();
        load_c();
        send_n(NPX);
        check_frame("ext");

`ifdef POOL_AVG_EN
        avg_mode = 1'b1;
        pulse_frame_start();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                frm[(r*4+c)*2]   = DW'((r % 2 == 1 && c % 2 == 1) ? 5 : 4);
                frm[(r*4+c)*2+1] = DW'((r % 2 == 1 && c % 2 == 1) ? 5 : 4);
            end
        end
        frm[0]  = DW'(1);
        frm[2]  = DW'(2);
        frm[8]  = DW'(3);
        frm[10] = DW'(-7);
        set_exp(-1, 4, 4, 4, 4, 4, 4, 4);
        send_n(NPX);
        check_frame("avg");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
